// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_pkg
// Description : Shared types and default constants for the audio stream paths.
// Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    typedef enum logic {
        AUDIO_MODE_I2S = 1'b0,
        AUDIO_MODE_LJ  = 1'b1
    } audio_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        LOAD  = 2'd2,
        SHIFT = 2'd3
    } tx_state_e;

    localparam int SAMPLE_W_DEF   = 24;
    localparam int SLOT_W_DEF     = 32;
    localparam int UNDERRUN_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/audio_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : audio_sync_fifo
// Description : Single-clock show-ahead FIFO with registered level/full/empty
//               and synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_sync_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_lw = c_aw + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_lw-1:0]  r_level;
    logic [c_lw-1:0]  w_level_nxt;
    logic             r_full;
    logic             r_empty;
    logic             w_push;
    logic             w_pop;

    // Flush wins over any same-cycle transfer so the level lands on zero.
    assign w_push = wr_en && !r_full && !flush;
    assign w_pop  = rd_en && !r_empty && !flush;

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + c_lw'(1);
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - c_lw'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == c_lw'(DEPTH));
            r_empty <= (w_level_nxt == '0);
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign level   = r_level;
    assign full    = r_full;
    assign empty   = r_empty;

endmodule
`default_nettype wire

// File: rtl/audio_dac_stream_tx.sv
`default_nettype none
// ============================================================================
// Module      : audio_dac_stream_tx
// Description : Buffered PCM stream to codec DACDAT serialiser, slaved to
//               external BCLK/DACLRCK. Optional underrun counter enabled by
//               defining AUDIO_DAC_UNDERRUN_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_dac_stream_tx
    import audio_pkg::*;
#(
    parameter int SAMPLE_W   = SAMPLE_W_DEF,
    parameter int SLOT_W     = SLOT_W_DEF,
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 64,
    parameter int MODE       = 0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          flush,
    input  logic [NUM_CH*SAMPLE_W-1:0]    s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic                          bclk_in,
    input  logic                          lrck_in,
    output logic                          dacdat,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    output logic [UNDERRUN_CNT_W-1:0]     underrun_count
);

    localparam int c_frame_w = NUM_CH * SLOT_W;
    localparam int c_cnt_w   = $clog2(c_frame_w + 1);
    localparam bit c_i2s     = (MODE == int'(AUDIO_MODE_I2S));

    logic [2:0]                   r_bclk_sync;
    logic [2:0]                   r_lrck_sync;
    logic                         w_fall_b;
    logic                         w_fall_lr;
    tx_state_e                    r_state;
    tx_state_e                    w_state_nxt;
    logic                         w_pop;
    logic                         w_fifo_full;
    logic                         w_fifo_empty;
    logic [NUM_CH*SAMPLE_W-1:0]   w_fifo_rd_data;
    logic [c_frame_w-1:0]         w_frame_load;
    logic [c_frame_w-1:0]         r_shift;
    logic [c_cnt_w-1:0]           r_bit_cnt;
    logic                         r_i2s_gap;
    logic                         r_dacdat;
    logic                         r_underrun;

    audio_sync_fifo #(
        .WIDTH (NUM_CH*SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .wr_en   (s_valid),
        .wr_data (s_data),
        .rd_en   (w_pop),
        .rd_data (w_fifo_rd_data),
        .level   (fifo_level),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty)
    );

    assign s_ready = !w_fifo_full;

    // Stage [0]/[1] synchronise, stage [2] is the delayed copy for edge detect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bclk_sync <= '0;
            r_lrck_sync <= '0;
        end else begin
            r_bclk_sync <= {r_bclk_sync[1:0], bclk_in};
            r_lrck_sync <= {r_lrck_sync[1:0], lrck_in};
        end
    end

    assign w_fall_b  = r_bclk_sync[2] && !r_bclk_sync[1];
    assign w_fall_lr = r_lrck_sync[2] && !r_lrck_sync[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (enable) w_state_nxt = ARM;
            ARM:     if (w_fall_lr) w_state_nxt = LOAD;
            LOAD:    w_state_nxt = SHIFT;
            SHIFT:   if (w_fall_lr) w_state_nxt = LOAD;
            default: w_state_nxt = IDLE;
        endcase
        if (!enable) begin
            w_state_nxt = IDLE;
        end
    end

    assign w_pop = (r_state == LOAD) && enable;

    // Channel 0 occupies the most significant slot so it leaves first.
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_slot
        assign w_frame_load[c_frame_w-1-ch*SLOT_W -: SLOT_W] =
            SLOT_W'(w_fifo_rd_data[ch*SAMPLE_W +: SAMPLE_W]) << (SLOT_W - SAMPLE_W);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_i2s_gap  <= 1'b0;
            r_dacdat   <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            case (r_state)
                LOAD: begin
                    if (enable) begin
                        r_shift    <= w_fifo_empty ? '0 : w_frame_load;
                        r_bit_cnt  <= '0;
                        r_i2s_gap  <= c_i2s;
                        r_underrun <= w_fifo_empty;
                    end
                end
                SHIFT: begin
                    // A coincident frame edge resyncs instead of shifting.
                    if (w_fall_b && !w_fall_lr && enable) begin
                        if (r_i2s_gap) begin
                            r_dacdat  <= 1'b0;
                            r_i2s_gap <= 1'b0;
                        end else if (r_bit_cnt != c_cnt_w'(c_frame_w)) begin
                            r_dacdat  <= r_shift[c_frame_w-1];
                            r_shift   <= r_shift << 1;
                            r_bit_cnt <= r_bit_cnt + c_cnt_w'(1);
                        end else begin
                            r_dacdat <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
            if (!enable || r_state == IDLE || r_state == ARM) begin
                r_dacdat <= 1'b0;
            end
        end
    end

    assign dacdat   = r_dacdat;
    assign underrun = r_underrun;

`ifdef AUDIO_DAC_UNDERRUN_CNT_EN
    logic [UNDERRUN_CNT_W-1:0] r_underrun_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_underrun_cnt <= '0;
        end else if (flush) begin
            r_underrun_cnt <= '0;
        end else if (r_underrun && (r_underrun_cnt != '1)) begin
            r_underrun_cnt <= r_underrun_cnt + UNDERRUN_CNT_W'(1);
        end
    end

    assign underrun_count = r_underrun_cnt;
`else
    assign underrun_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_audio_dac_stream_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_dac_stream_tx
// Description : Self-checking bench; I2S and left-justified instances share
//               all inputs and are compared against a bit-level frame model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_audio_dac_stream_tx;

    localparam int SW    = 24;
    localparam int SLW   = 32;
    localparam int NCH   = 2;
    localparam int DEPTH = 64;
    localparam int NB    = NCH * SLW;
    localparam int DW    = NCH * SW;

    typedef struct {
        logic          valid;
        logic          flush;
        logic [DW-1:0] data;
        int            exp_level;
        logic          exp_ready;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          flush = 1'b0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          bclk_in = 1'b0;
    logic          lrck_in = 1'b1;
    logic          s_ready_i2s, s_ready_lj;
    logic          dacdat_i2s, dacdat_lj;
    logic          underrun_i2s, underrun_lj;
    logic [6:0]    level_i2s, level_lj;
    logic [15:0]   urc_i2s, urc_lj;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] cur_frame = '0;
    bit            frame_active = 0;
    bit            model_en = 1;
    int            pos = 0;
    int            m_ur = 0;
    int            m_ur_base = 0;
    int            ur_seen_i2s = 0;
    int            ur_seen_lj = 0;
    vec_t          tbl[10];

    always #5 clk = ~clk;

    audio_dac_stream_tx #(.SAMPLE_W(SW), .SLOT_W(SLW), .NUM_CH(NCH), .FIFO_DEPTH(DEPTH), .MODE(0)) u_dut_i2s (
        .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_i2s),
        .bclk_in(bclk_in), .lrck_in(lrck_in), .dacdat(dacdat_i2s),
        .fifo_level(level_i2s), .underrun(underrun_i2s), .underrun_count(urc_i2s)
    );

    audio_dac_stream_tx #(.SAMPLE_W(SW), .SLOT_W(SLW), .NUM_CH(NCH), .FIFO_DEPTH(DEPTH), .MODE(1)) u_dut_lj (
        .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_lj),
        .bclk_in(bclk_in), .lrck_in(lrck_in), .dacdat(dacdat_lj),
        .fifo_level(level_lj), .underrun(underrun_lj), .underrun_count(urc_lj)
    );

    always @(negedge clk) begin
        if (underrun_i2s) ur_seen_i2s++;
        if (underrun_lj)  ur_seen_lj++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Serial bit idx of a frame: slots back to back, channel 0 first,
    // sample MSB first, zero padding after the sample.
    function automatic logic exp_bit(input logic [DW-1:0] fr, input int idx);
        int ch, b;
        if (idx < 0 || idx >= NB) return 1'b0;
        ch = idx / SLW;
        b  = idx % SLW;
        if (b >= SW) return 1'b0;
        return fr[ch*SW + SW - 1 - b];
    endfunction

    task automatic model_frame_start();
        cur_frame = '0;
        if (model_en) begin
            if (model_q.size() > 0) cur_frame = model_q.pop_front();
            else m_ur++;
        end
        frame_active = 1;
    endtask

    task automatic check_counts(input string tag);
        int exp_cnt;
`ifdef AUDIO_DAC_UNDERRUN_CNT_EN
        exp_cnt = m_ur - m_ur_base;
`else
        exp_cnt = 0;
`endif
        check({tag, "_pulses_i2s"}, ur_seen_i2s, m_ur);
        check({tag, "_pulses_lj"}, ur_seen_lj, m_ur);
        check({tag, "_count_i2s"}, urc_i2s, exp_cnt);
        check({tag, "_count_lj"}, urc_lj, exp_cnt);
    endtask

    task automatic push_frame(input logic [DW-1:0] d);
        @(negedge clk);
        check("s_ready_push", s_ready_i2s, (model_q.size() < DEPTH));
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        s_valid = 1'b0;
        model_q.push_back(d);
    endtask

    task automatic flush_pulse();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_q.delete();
        m_ur_base = m_ur;
    endtask

    // Drives nrises BCLK periods (clk/8). The first rise is a frame start;
    // LRCK falls every NB rises, and optionally early at rise inject_at.
    task automatic play(input int nrises, input int inject_at);
        bit injected;
        int hi_wait;
        injected = 0;
        @(posedge clk);
        #3;
        lrck_in = 1'b1;
        frame_active = 0;
        pos = NB - 1;
        #30;
        for (int i = 0; i < nrises; i++) begin
            hi_wait = 40;
            bclk_in = 1'b1;
            pos++;
            if (frame_active) begin
                check("dacdat_i2s", dacdat_i2s, exp_bit(cur_frame, pos - 2));
                check("dacdat_lj", dacdat_lj, exp_bit(cur_frame, pos - 1));
            end
            if (i < nrises - 1) begin
                if (pos == NB) begin
                    lrck_in = 1'b0;
                    pos = 0;
                    model_frame_start();
                end else if (pos == inject_at && !injected) begin
                    injected = 1;
                    lrck_in = 1'b1;
                    #10 lrck_in = 1'b0;
                    hi_wait = 30;
                    pos = 0;
                    model_frame_start();
                end else if (pos == NB / 2) begin
                    lrck_in = 1'b1;
                end
            end
            #(hi_wait) bclk_in = 1'b0;
            #40;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n, before_i2s;
        logic [DW-1:0] held;

        tbl[0] = '{1'b1, 1'b0, DW'({$urandom, $urandom}), 1, 1'b1};
        tbl[1] = '{1'b1, 1'b0, DW'({$urandom, $urandom}), 2, 1'b1};
        tbl[2] = '{1'b0, 1'b0, '0, 2, 1'b1};
        tbl[3] = '{1'b1, 1'b1, DW'({$urandom, $urandom}), 0, 1'b1};
        tbl[4] = '{1'b1, 1'b0, DW'({$urandom, $urandom}), 1, 1'b1};
        tbl[5] = '{1'b0, 1'b1, '0, 0, 1'b1};
        tbl[6] = '{1'b1, 1'b0, {24'h123456, 24'hABCDEF}, 1, 1'b1};
        tbl[7] = '{1'b1, 1'b0, DW'({$urandom, $urandom}), 2, 1'b1};
        tbl[8] = '{1'b0, 1'b0, '0, 2, 1'b1};
        tbl[9] = '{1'b1, 1'b0, DW'({$urandom, $urandom}), 3, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_level", level_i2s, 0);
        check("rst_ready", s_ready_i2s, 1);
        check("rst_dacdat_i2s", dacdat_i2s, 0);
        check("rst_dacdat_lj", dacdat_lj, 0);
        check("rst_underrun", underrun_i2s, 0);
        check("rst_count", urc_i2s, 0);

        // FIFO push/flush vectors, serialiser disabled
        for (int i = 0; i < 10; i++) begin
            s_valid = tbl[i].valid;
            flush   = tbl[i].flush;
            s_data  = tbl[i].data;
            @(negedge clk);
            s_valid = 1'b0;
            flush   = 1'b0;
            if (tbl[i].flush) begin
                model_q.delete();
                m_ur_base = m_ur;
            end else if (tbl[i].valid) begin
                model_q.push_back(tbl[i].data);
            end
            check("vec_level_i2s", level_i2s, tbl[i].exp_level);
            check("vec_level_lj", level_lj, tbl[i].exp_level);
            check("vec_ready", s_ready_i2s, tbl[i].exp_ready);
        end

        // Known frame then two more, then one underrun
        enable = 1'b1;
        repeat (4) @(negedge clk);
        play(1 + NB * 4, -1);
        check_counts("basic");

        // Empty FIFO: three underrun frames of silence
        flush_pulse();
        play(1 + NB * 3, -1);
        check("ur3_delta", m_ur - m_ur_base, 3);
        check_counts("underrun3");

        // Randomised frames with random push spacing
        for (int it = 0; it < 3; it++) begin
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                push_frame(DW'({$urandom, $urandom}));
            end
            play(1 + NB * (n + 1), -1);
            check("rand_level", level_i2s, 0);
        end
        check_counts("random");

        // Early frame edge after 10 bits: resync, no extra underrun
        for (int j = 0; j < 3; j++) push_frame(DW'({$urandom, $urandom}));
        before_i2s = ur_seen_i2s;
        play(1 + 10 + NB * 2, 10);
        check("resync_no_underrun", ur_seen_i2s, before_i2s);
        check_counts("resync");

        // Disabled: no pops, silent output
        push_frame(DW'({$urandom, $urandom}));
        push_frame(DW'({$urandom, $urandom}));
        @(negedge clk);
        enable = 1'b0;
        model_en = 0;
        play(1 + NB, -1);
        check("disabled_level", level_i2s, 2);
        enable = 1'b1;
        model_en = 1;
        repeat (4) @(negedge clk);

        // Fill to full, hold one frame until a pop frees space
        while (model_q.size() < DEPTH) push_frame(DW'({$urandom, $urandom}));
        @(negedge clk);
        check("full_level", level_i2s, DEPTH);
        check("full_ready", s_ready_i2s, 0);
        held = DW'({$urandom, $urandom});
        s_valid = 1'b1;
        s_data  = held;
        repeat (5) @(negedge clk);
        check("held_level", level_i2s, DEPTH);
        play(3, -1);
        @(negedge clk);
        s_valid = 1'b0;
        model_q.push_back(held);
        check("held_accepted_level", level_lj, DEPTH);
        check("held_ready", s_ready_lj, 0);
        play(1 + NB * DEPTH, -1);
        check("drain_level", level_i2s, 0);
        check_counts("drain");

        // Asynchronous reset in the middle of a frame
        for (int j = 0; j < 6; j++) push_frame('1);
        play(21, -1);
        check("pre_rst_level", level_i2s, 5);
        check("pre_rst_dacdat", dacdat_lj, exp_bit(cur_frame, pos));
        #12 reset_n = 1'b0;
        #2;
        check("async_rst_dacdat_i2s", dacdat_i2s, 0);
        check("async_rst_dacdat_lj", dacdat_lj, 0);
        check("async_rst_level", level_i2s, 0);
        model_q.delete();
        m_ur_base = m_ur;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", s_ready_i2s, 1);
        check("post_rst_level", level_lj, 0);
        check("post_rst_dacdat", dacdat_i2s, 0);
        check_counts("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
